// File: rtl/can_bus_regif.sv
// Wishbone classic slave front-end for the CAN controller register bank.
// Registers each access and turns it into a one-cycle write or read strobe, then acks.
module can_bus_regif #(
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 32,
  parameter int PROT_LO  = 4,
  parameter int PROT_HI  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [7:0]          wb_dat_i,
  output logic [7:0]          wb_dat_o,
  output logic                wb_ack_o,
  input  logic                reset_mode,
  output logic [NUM_REGS-1:0] reg_we,
  output logic [7:0]          reg_wdata,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic                reg_re,
  input  logic [7:0]          reg_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, DONE} state_t;

  state_t state, state_nxt;
  logic   we_q;
  logic   in_range, prot, wr_ok;

  assign in_range = {1'b0, reg_addr} < (ADDR_W+1)'(NUM_REGS);
  assign prot     = (reg_addr >= ADDR_W'(PROT_LO)) && (reg_addr <= ADDR_W'(PROT_HI));
  // Configuration registers only accept writes while the controller is in reset mode.
  assign wr_ok    = in_range && !(prot && !reset_mode);

  always_comb begin
    state_nxt = state;
    reg_we    = '0;
    reg_re    = 1'b0;
    wb_ack_o  = 1'b0;
    case (state)
      IDLE:   if (wb_cyc_i && wb_stb_i) state_nxt = ACCESS;
      ACCESS: begin
        state_nxt = ACK;
        if (we_q) begin
          for (int i = 0; i < NUM_REGS; i++)
            reg_we[i] = wr_ok && (reg_addr == ADDR_W'(i));
        end else begin
          reg_re = 1'b1;
        end
      end
      ACK: begin
        wb_ack_o  = 1'b1;
        state_nxt = DONE;
      end
      DONE:   if (!wb_stb_i || !wb_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      wb_dat_o  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && wb_cyc_i && wb_stb_i) begin
        reg_addr  <= wb_adr_i;
        reg_wdata <= wb_dat_i;
        we_q      <= wb_we_i;
      end
      // Unimplemented addresses read as zero regardless of what the bank mux returns.
      if (state == ACCESS && !we_q)
        wb_dat_o <= in_range ? reg_rdata : 8'h00;
    end
  end

endmodule

// File: tb/tb_can_bus_regif.sv
// Scoreboard bench for can_bus_regif: a stimulus process queues expected outcomes from a
// register-map model; a monitor pops and checks them on every ack.
module tb_can_bus_regif;
  localparam int ADDR_W   = 8;
  localparam int NUM_REGS = 32;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [ADDR_W-1:0]   wb_adr_i = '0;
  logic [7:0]          wb_dat_i = '0;
  logic [7:0]          wb_dat_o;
  logic                wb_ack_o;
  logic                reset_mode = 1'b0;
  logic [NUM_REGS-1:0] reg_we;
  logic [7:0]          reg_wdata;
  logic [ADDR_W-1:0]   reg_addr;
  logic                reg_re;
  logic [7:0]          reg_rdata;

  can_bus_regif #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .PROT_LO(4), .PROT_HI(8)) dut (
    .clk(clk), .rst_n(rst_n), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .reset_mode(reset_mode), .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_addr(reg_addr),
    .reg_re(reg_re), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    int          addr;
    logic [7:0]  data;
    logic [31:0] exp_we;
    logic [7:0]  exp_dat;
    int          req_cyc;
  } exp_t;

  exp_t        q[$];
  int          total = 0, bad = 0, cyc_n = 0;
  logic [7:0]  bank    [NUM_REGS];
  logic [7:0]  ref_mem [NUM_REGS];

  function automatic logic [7:0] init_val(int i);
    return 8'(i * 29 + 7);
  endfunction

  function automatic bit is_cor(int a);
    return a == 3 || a == 11 || a == 12;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Register bank: resets with the controller, clear-on-read for IR/ALC/ECC.
  assign reg_rdata = (reg_addr < NUM_REGS) ? bank[reg_addr[4:0]] : 8'hEE;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= init_val(i);
    end else begin
      for (int i = 0; i < NUM_REGS; i++) if (reg_we[i]) bank[i] <= reg_wdata;
      if (reg_re && reg_addr < NUM_REGS && is_cor(int'(reg_addr))) bank[reg_addr[4:0]] <= 8'h00;
    end
  end

  // Monitor
  logic [31:0] acc_we;
  int          we_cnt, re_cnt, we_cyc, re_cyc;
  logic [7:0]  acc_wdata;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      acc_we = '0; we_cnt = 0; re_cnt = 0; we_cyc = -1; re_cyc = -1; acc_wdata = '0;
    end else begin
      if (|reg_we || reg_re) begin
        chk("we_onehot", 32'($countones(reg_we) <= 1), 32'd1);
        chk("we_re_excl", 32'(|reg_we && reg_re), 32'd0);
      end
      if (|reg_we) begin acc_we |= reg_we; we_cnt++; acc_wdata = reg_wdata; we_cyc = cyc_n; end
      if (reg_re) begin re_cnt++; re_cyc = cyc_n; end
      if (wb_ack_o) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: got ack want none (cycle %0d)", cyc_n);
        end else begin
          e = q.pop_front();
          chk("ack_latency", 32'(cyc_n), 32'(e.req_cyc + 1));
          if (e.we) begin
            chk("we_vec", acc_we, e.exp_we);
            chk("we_cnt", 32'(we_cnt), 32'(e.exp_we != 0));
            chk("wr_re_cnt", 32'(re_cnt), 32'd0);
            if (e.exp_we != 0) begin
              chk("wdata", 32'(acc_wdata), 32'(e.data));
              chk("we_cycle", 32'(we_cyc), 32'(e.req_cyc));
            end
          end else begin
            chk("re_cnt", 32'(re_cnt), 32'd1);
            chk("re_cycle", 32'(re_cyc), 32'(e.req_cyc));
            chk("rd_we_vec", acc_we, 32'd0);
            chk("rdata", 32'(wb_dat_o), 32'(e.exp_dat));
          end
        end
        acc_we = '0; we_cnt = 0; re_cnt = 0; we_cyc = -1; re_cyc = -1;
      end
    end
  end

  task automatic access(input bit we, input int a, input logic [7:0] d, input bit rm,
                        input int hold, input bit early_drop);
    exp_t e;
    bit   seen;
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = 8'(a); wb_dat_i = d; reset_mode = rm;
    e.we = we; e.addr = a; e.data = d; e.exp_we = '0; e.exp_dat = 8'h00;
    e.req_cyc = cyc_n + 1;
    if (we) begin
      if (a < NUM_REGS && !(a >= 4 && a <= 8 && !rm)) begin
        e.exp_we = 32'd1 << a;
        ref_mem[a] = d;
      end
    end else if (a < NUM_REGS) begin
      e.exp_dat = ref_mem[a];
      if (is_cor(a)) ref_mem[a] = 8'h00;
    end
    q.push_back(e);
    if (early_drop) begin @(posedge clk); #1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin @(negedge clk); seen = wb_ack_o; end
    if (!seen) begin
      total++; bad++;
      $display("FAIL ack_timeout: got no ack want ack for addr %0d", a);
      q.delete();
    end
    @(posedge clk);
    repeat (hold) @(posedge clk);
    #1; wb_cyc_i = 1'($urandom_range(0, 1)); wb_stb_i = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_we"}, reg_we, 32'd0);
    chk({tag, "_re"}, 32'(reg_re), 32'd0);
    chk({tag, "_ack"}, 32'(wb_ack_o), 32'd0);
    chk({tag, "_dat"}, 32'(wb_dat_o), 32'd0);
    chk({tag, "_wdata"}, 32'(reg_wdata), 32'd0);
    chk({tag, "_addr"}, 32'(reg_addr), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) ref_mem[i] = init_val(i);
    repeat (2) @(posedge clk);
    #1; chk_idle_outputs("rst");
    rst_n = 1'b1;

    // Reset in the middle of a write ACCESS aborts it.
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 8'd2; wb_dat_i = 8'h77;
    @(posedge clk); #1;
    chk("pre_rst_we", reg_we, 32'd1 << 2);
    rst_n = 1'b0; #1;
    chk_idle_outputs("mid_rst");
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1; chk_idle_outputs("post_rst");
    chk("post_rst_bank2", 32'(bank[2]), 32'(init_val(2)));

    access(1, 1, 8'hA5, 0, 0, 0);
    access(1, 6, 8'h3C, 0, 0, 0);
    access(0, 6, 8'h00, 0, 0, 0);
    access(1, 6, 8'h3C, 1, 0, 0);
    access(0, 6, 8'h00, 0, 0, 0);
    access(1, 4, 8'h11, 0, 0, 0);
    access(1, 8, 8'h22, 0, 0, 0);
    access(1, 3, 8'h33, 0, 0, 0);
    access(1, 9, 8'h44, 0, 0, 0);
    access(0, 4, 8'h00, 1, 0, 0);
    access(0, 9, 8'h00, 0, 0, 0);
    access(1, 3, 8'h81, 0, 0, 0);
    access(0, 3, 8'h00, 0, 0, 0);
    access(0, 3, 8'h00, 0, 0, 0);
    access(1, 40, 8'hFF, 1, 0, 0);
    access(0, 40, 8'h00, 1, 0, 0);
    access(0, 5, 8'h00, 0, 3, 0);
    access(1, 5, 8'h5A, 1, 0, 0);
    access(0, 5, 8'h00, 0, 0, 1);

    for (int n = 0; n < 300; n++)
      access(1'($urandom_range(0, 1)), int'($urandom_range(0, 47)), 8'($urandom),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0));

    repeat (4) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/can_bus_regif.md
Name: can_bus_regif

Overview:
- Host-side register interface of the CAN controller.
- Terminates the 8-bit Wishbone classic slave bus and registers each access.
- For writes, produces the one-hot write-enable strobes and write data that drive the register bank's write-enabled storage elements.
- For reads, returns bank read data and issues a read strobe so clear-on-read registers (IR, ALC, ECC) can clear.
- Enforces reset-mode write protection on configuration registers.

Parameters:
- ADDR_W, 8, width of wb_adr_i.
- NUM_REGS, 32, number of implemented register addresses (0..NUM_REGS-1); NUM_REGS <= 2**ADDR_W.
- PROT_LO, 4, lowest address writable only in reset mode.
- PROT_HI, 8, highest address writable only in reset mode (inclusive); PROT_LO <= PROT_HI < NUM_REGS.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe/request.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  ADDR_W  register address.
- wb_dat_i  in  8  write data.
- wb_dat_o  out  8  read data, valid while wb_ack_o = 1.
- wb_ack_o  out  1  single-cycle acknowledge.
- reset_mode  in  1  controller reset-mode bit from the mode register.
- reg_we  out  NUM_REGS  one-hot write strobe, bit n = write register n.
- reg_wdata  out  8  registered write data, valid when any reg_we bit = 1.
- reg_addr  out  ADDR_W  registered access address (read mux select).
- reg_re  out  1  single-cycle read strobe for clear-on-read.
- reg_rdata  in  8  bank read data, combinational from reg_addr.

Behaviour:
- Reset (rst_n = 0, asynchronous): state = IDLE; wb_ack_o = 0, wb_dat_o = 0x00, reg_we = 0, reg_wdata = 0x00, reg_addr = 0, reg_re = 0.
- Reset mid-access aborts the access: no strobe fires and no ack is given.
- States: IDLE, ACCESS, ACK, DONE.
- IDLE: when wb_cyc_i & wb_stb_i = 1, latch wb_adr_i into reg_addr, wb_dat_i into reg_wdata and wb_we_i into an internal we flag, then go to ACCESS. Otherwise stay.
- ACCESS (exactly 1 cycle), write: reg_we[reg_addr] = 1 for this cycle only, provided all of the following hold:
  - reg_addr < NUM_REGS;
  - not (PROT_LO <= reg_addr <= PROT_HI and reset_mode = 0).
  Otherwise no strobe fires. Either way, go to ACK.
- ACCESS, read: reg_re = 1 for this cycle.
  - Sample wb_dat_o <= reg_rdata at the end of the cycle if reg_addr < NUM_REGS, else wb_dat_o <= 0x00. reg_re still pulses for an out-of-range address.
  - Go to ACK.
- ACK (1 cycle): wb_ack_o = 1; wb_dat_o holds its value. Go to DONE.
- DONE: wait until wb_stb_i = 0 or wb_cyc_i = 0, then go to IDLE. A new request is never accepted in the cycle right after ack.
- Latency: request sampled at edge N; strobe during cycle N+1; wb_ack_o high during cycle N+2. Minimum back-to-back spacing is 4 cycles.
- wb_cyc_i dropped while in ACCESS or ACK: the access completes internally (strobe fires, ack pulses); the master ignores the ack.
- reset_mode is sampled during ACCESS, not at request time.
- Dropped writes (protected or out of range) are still acked; there is no error signal.
- reg_we is never multi-hot. reg_we and reg_re are never high together.
- reg_wdata and reg_addr hold their values until the next accepted request.

Test Plan:
- Reset: assert rst_n = 0 mid-ACCESS of a write to addr 2 -> reg_we = 0 immediately; wb_ack_o never pulses; after release, state is IDLE and all outputs are 0.
- Unprotected write: addr 0x01, data 0xA5, reset_mode = 0 -> reg_we = 0x00000002 for exactly one cycle (request edge + 1), reg_wdata = 0xA5, wb_ack_o high one cycle later.
- Protection: write 0x3C to addr 6 with reset_mode = 0 -> reg_we stays 0, ack still pulses. Repeat with reset_mode = 1 -> reg_we[6] pulses with reg_wdata = 0x3C. Also cover boundary addresses 4, 8 (protected) and 3, 9 (not protected).
- Read with clear-on-read: addr 3, bank returns 0x81 -> reg_re pulses one cycle, wb_dat_o = 0x81 while wb_ack_o = 1; bank model clears after reg_re, and a second read returns 0x00.
- Out of range: write 0xFF to addr 40 (NUM_REGS = 32) -> no reg_we bit set, ack given. Read from addr 40 -> wb_dat_o = 0x00 and reg_re pulses.
- Held strobe: master keeps wb_stb_i = 1 for 3 cycles after ack -> exactly one strobe and one ack. After stb drops for one cycle and reasserts, a second access proceeds normally.
